tdoa_pairing: RTL and testbench
===============================

TDOA_PAIRING -- requirements
Module: tdoa_pairing

Interface
REQ-001 Parameter MAX_LAG, default 100000: the maximum number of clock cycles allowed between partner events for them to form a pair.
REQ-002 Parameter AVG_LOG2, default 2: the number of pairs averaged per output is 2^AVG_LOG2 (legal range 0..6).
REQ-003 clock  input  1  reference clock; all logic SHALL be clocked on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 time_1  input  32  latest mic1 rising-edge timestamp from the phase-detection stage.
REQ-006 time_2  input  32  latest mic2 rising-edge timestamp from the phase-detection stage.
REQ-007 delta  output  32  signed averaged (time_2 - time_1), two's complement.
REQ-008 delta_valid  output  1  delta is valid.
REQ-009 delta_ready  input  1  consumer accepts delta.
REQ-010 timeout_count  output  16  count of unpaired events discarded, saturating.

Function
REQ-011 Event detection SHALL compare each timestamp input against a registered copy; an event occurs in any cycle where they differ. The copies SHALL update every cycle in all states.
REQ-012 The FSM SHALL have states IDLE, WAIT_2, WAIT_1 and OUTPUT.
REQ-013 IDLE transitions:
- event on 1 only: latch time_1, clear the lag counter, go to WAIT_2.
- event on 2 only: latch time_2, clear the lag counter, go to WAIT_1.
- events on both in the same cycle: form a pair immediately and stay in IDLE (or go to OUTPUT per REQ-017).
REQ-014 WAIT_2 transitions:
- event on 2: form a pair.
- repeated event on 1: replace the latched t1 and clear the lag counter.
- both in the same cycle: pair using the new time_2 and the previously latched t1.
- WAIT_1 SHALL behave symmetrically.
REQ-015 Lag counter in the WAIT states:
- It SHALL increment once per cycle.
- At the edge where it equals MAX_LAG with no partner event, the FSM SHALL return to IDLE and increment timeout_count, saturating at 0xFFFF.
- A partner event at that same edge SHALL win, forming a pair with no timeout.
REQ-016 Pair difference SHALL be computed as (t2 - t1) mod 2^32 and interpreted as signed 32-bit, so counter wrap-around yields the correct small difference.
REQ-017 Accumulation and output:
- Each pair SHALL add its difference, sign-extended, into a (32+AVG_LOG2)-bit signed accumulator and increment a pair counter.
- At the edge where the pair counter reaches 2^AVG_LOG2, the block SHALL load delta with (accumulator + difference) arithmetically shifted right by AVG_LOG2 (floor), truncated to 32 bits.
- At that same edge it SHALL set delta_valid, clear the accumulator and pair counter, and enter OUTPUT.
REQ-018 Latency: delta_valid SHALL be high in the cycle immediately after the edge at which the final pair's event was sampled.
REQ-019 In OUTPUT, delta and delta_valid SHALL remain stable until a cycle in which delta_valid and delta_ready are both high; at that edge delta_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-020 Events arriving in OUTPUT SHALL be dropped; they SHALL NOT count as timeouts or enter the accumulator.
REQ-021 delta SHALL retain its last value after the handshake until the next output load.

Reset
REQ-022 While reset is high, the block SHALL hold these values:
- delta = 0, delta_valid = 0, timeout_count = 0.
- FSM in IDLE; accumulator, pair counter and lag counter at 0.
- Registered copies loaded with the current time_1/time_2, so no spurious event occurs after reset.
REQ-023 Reset asserted in any state, including WAIT_x and OUTPUT mid-handshake, SHALL discard all partial accumulation and pending timestamps at the next edge.

Verification
All scenarios use AVG_LOG2=2 and MAX_LAG=100.
REQ-024 Four pairs with (t1, t2) = (1000, 1010), (2000, 2010), (3000, 3010), (4000, 4010), each t2 arriving 10 cycles after t1 -> delta=10, delta_valid high one cycle after the 4th time_2 event.
REQ-025 Four pairs with differences -1, -1, -1, -2 -> delta = floor(-5/4) = -2 = 0xFFFFFFFE.
REQ-026 Pair t1=0xFFFFFFF0 with t2=0x00000010 (plus three pairs of difference 32) -> delta=32.
REQ-027 Lag boundaries:
- time_1 event only -> timeout_count=1 exactly 100 cycles later, FSM in IDLE.
- Repeat with the time_2 event at lag 100 -> a pair forms, timeout_count unchanged.
REQ-028 Backpressure: hold delta_ready=0 for 20 cycles after delta_valid while injecting 3 events -> delta and delta_valid stable, dropped events do not change the next average.
- Raise delta_ready -> delta_valid low the next cycle.
REQ-029 Reset mid-operation: assert reset in WAIT_2 after two accumulated pairs -> all outputs 0.
- Four fresh pairs of difference 7 then yield delta=7.

Source files
------------

// File: rtl/tdoa_pairing.sv
// Pairs mic1/mic2 rising-edge timestamps into (time_2 - time_1) differences,
// averages 2^AVG_LOG2 pairs and presents the result over a valid/ready handshake.
//
// Ports:
//   clock          reference clock, everything on posedge
//   reset          synchronous, active-high
//   time_1         latest mic1 timestamp; a change of value is an event
//   time_2         latest mic2 timestamp; a change of value is an event
//   delta          signed averaged (time_2 - time_1)
//   delta_valid    delta holds a fresh average
//   delta_ready    consumer accepts delta
//   timeout_count  saturating count of unpaired events discarded on lag expiry
module tdoa_pairing #(
  parameter int unsigned MAX_LAG  = 100000,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] time_1,
  input  logic [31:0] time_2,
  output logic [31:0] delta,
  output logic        delta_valid,
  input  logic        delta_ready,
  output logic [15:0] timeout_count
);

  localparam int unsigned AccW     = 32 + AVG_LOG2;
  localparam logic [31:0] MaxLag   = 32'(MAX_LAG);
  localparam logic [6:0]  LastPair = 7'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait2  = 2'd1;
  localparam logic [1:0] StWait1  = 2'd2;
  localparam logic [1:0] StOutput = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [31:0]            t1_prev_q, t2_prev_q;
  logic [31:0]            t1_lat_q, t1_lat_d;
  logic [31:0]            t2_lat_q, t2_lat_d;
  logic [31:0]            lag_q, lag_d;
  logic [15:0]            timeout_q, timeout_d;
  logic [31:0]            delta_q, delta_d;
  logic                   valid_q, valid_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [6:0]             cnt_q, cnt_d;

  logic                   ev1, ev2;
  logic                   pair_fire;
  logic signed [31:0]     pair_diff;
  logic signed [AccW-1:0] acc_sum;

  // An event is any cycle in which the timestamp differs from last cycle's copy.
  assign ev1 = (time_1 != t1_prev_q);
  assign ev2 = (time_2 != t2_prev_q);

  always_comb begin
    state_d   = state_q;
    t1_lat_d  = t1_lat_q;
    t2_lat_d  = t2_lat_q;
    lag_d     = lag_q;
    timeout_d = timeout_q;
    delta_d   = delta_q;
    valid_d   = valid_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pair_fire = 1'b0;
    pair_diff = '0;

    case (state_q)
      StIdle: begin
        if (ev1 && ev2) begin
          pair_fire = 1'b1;
          pair_diff = time_2 - time_1;
        end else if (ev1) begin
          t1_lat_d = time_1;
          lag_d    = '0;
          state_d  = StWait2;
        end else if (ev2) begin
          t2_lat_d = time_2;
          lag_d    = '0;
          state_d  = StWait1;
        end
      end
      StWait2: begin
        // Partner wins over both a repeated own event and lag expiry.
        if (ev2) begin
          pair_fire = 1'b1;
          pair_diff = time_2 - t1_lat_q;
          state_d   = StIdle;
        end else if (ev1) begin
          t1_lat_d = time_1;
          lag_d    = '0;
        end else if (lag_q == MaxLag) begin
          if (timeout_q != 16'hFFFF) timeout_d = timeout_q + 16'd1;
          state_d = StIdle;
        end else begin
          lag_d = lag_q + 32'd1;
        end
      end
      StWait1: begin
        if (ev1) begin
          pair_fire = 1'b1;
          pair_diff = t2_lat_q - time_1;
          state_d   = StIdle;
        end else if (ev2) begin
          t2_lat_d = time_2;
          lag_d    = '0;
        end else if (lag_q == MaxLag) begin
          if (timeout_q != 16'hFFFF) timeout_d = timeout_q + 16'd1;
          state_d = StIdle;
        end else begin
          lag_d = lag_q + 32'd1;
        end
      end
      StOutput: begin
        // Events here are dropped; the prev copies still track the inputs.
        if (valid_q && delta_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Include the current pair in the sum so the output is ready the next cycle.
    acc_sum = acc_q + AccW'(pair_diff);
    if (pair_fire) begin
      if (cnt_q == LastPair) begin
        delta_d = 32'(acc_sum >>> AVG_LOG2);
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StOutput;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    // Copies follow the inputs even in reset so no event appears on release.
    t1_prev_q <= time_1;
    t2_prev_q <= time_2;
    if (reset) begin
      state_q   <= StIdle;
      t1_lat_q  <= '0;
      t2_lat_q  <= '0;
      lag_q     <= '0;
      timeout_q <= '0;
      delta_q   <= '0;
      valid_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      t1_lat_q  <= t1_lat_d;
      t2_lat_q  <= t2_lat_d;
      lag_q     <= lag_d;
      timeout_q <= timeout_d;
      delta_q   <= delta_d;
      valid_q   <= valid_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign delta         = delta_q;
  assign delta_valid   = valid_q;
  assign timeout_count = timeout_q;

endmodule

// File: tb/tb_tdoa_pairing.sv
// Bench for tdoa_pairing with MAX_LAG=100, AVG_LOG2=2. Directed pairs push the
// expected average into a queue; a monitor compares it on each handshake.
module tb_tdoa_pairing;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] time_1 = 32'd0;
  logic [31:0] time_2 = 32'd0;
  logic        delta_ready = 1'b1;
  logic [31:0] delta;
  logic        delta_valid;
  logic [15:0] timeout_count;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  tdoa_pairing #(
    .MAX_LAG (100),
    .AVG_LOG2(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .time_1       (time_1),
    .time_2       (time_2),
    .delta        (delta),
    .delta_valid  (delta_valid),
    .delta_ready  (delta_ready),
    .timeout_count(timeout_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // time_1 sampled at the first edge, time_2 exactly gap edges later.
  task automatic pair(input logic [31:0] a, input logic [31:0] b, input int gap);
    time_1 = a;
    repeat (gap) tick();
    time_2 = b;
    tick();
    repeat (2) tick();
  endtask

  // Scoreboard monitor: compare on every accepted output.
  always @(negedge clock) begin
    if (!reset && delta_valid && delta_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got %0h, expected none", delta);
      end else begin
        mon_exp = exp_q.pop_front();
        if (delta !== mon_exp) begin
          failures++;
          $display("FAIL delta_out: got %0h, expected %0h", delta, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (3) tick();
    check("rst_delta", delta, 32'd0);
    check("rst_valid", {31'd0, delta_valid}, 32'd0);
    check("rst_timeout", {16'd0, timeout_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Four pairs of +10, with latency check on the last one.
    exp_q.push_back(32'd10);
    pair(32'd1000, 32'd1010, 10);
    pair(32'd2000, 32'd2010, 10);
    pair(32'd3000, 32'd3010, 10);
    time_1 = 32'd4000;
    repeat (10) tick();
    time_2 = 32'd4010;
    check("lat_before", {31'd0, delta_valid}, 32'd0);
    tick();
    check("lat_valid", {31'd0, delta_valid}, 32'd1);
    check("lat_delta", delta, 32'd10);
    tick();
    check("hs_clear", {31'd0, delta_valid}, 32'd0);
    tick();

    // -1,-1,-1,-2 -> floor(-5/4) = -2.
    exp_q.push_back(32'hFFFF_FFFE);
    pair(32'd5000, 32'd4999, 4);
    pair(32'd6000, 32'd5999, 4);
    pair(32'd7000, 32'd6999, 4);
    pair(32'd8000, 32'd7998, 4);

    // Counter wrap: 0x10 - 0xFFFFFFF0 = 32.
    exp_q.push_back(32'd32);
    pair(32'hFFFF_FFF0, 32'h0000_0010, 6);
    pair(32'd9000, 32'd9032, 6);
    pair(32'd10000, 32'd10032, 6);
    pair(32'd11000, 32'd11032, 6);

    // Lag expiry with no partner.
    time_1 = 32'd20000;
    tick();
    repeat (100) tick();
    check("lag_before_expiry", {16'd0, timeout_count}, 32'd0);
    tick();
    check("lag_timeout", {16'd0, timeout_count}, 32'd1);
    check("lag_idle", {30'd0, dut.state_q}, 32'd0);
    tick();

    // Partner at lag 100 wins; three more pairs complete the average of 101.
    exp_q.push_back(32'd101);
    pair(32'd21000, 32'd21101, 101);
    check("lag_partner_wins", {16'd0, timeout_count}, 32'd1);
    pair(32'd22000, 32'd22101, 5);
    pair(32'd23000, 32'd23101, 5);
    pair(32'd24000, 32'd24101, 5);

    // Backpressure with dropped events.
    delta_ready = 1'b0;
    exp_q.push_back(32'd3);
    pair(32'd30000, 32'd30003, 3);
    pair(32'd31000, 32'd31003, 3);
    pair(32'd32000, 32'd32003, 3);
    pair(32'd33000, 32'd33003, 3);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) time_1 = 32'd60000;
      if (i == 8) time_2 = 32'd60001;
      if (i == 13) time_1 = 32'd60002;
      tick();
      if (i == 0 || i == 9 || i == 19) begin
        check("bp_valid", {31'd0, delta_valid}, 32'd1);
        check("bp_delta", delta, 32'd3);
      end
    end
    delta_ready = 1'b1;
    tick();
    check("bp_release", {31'd0, delta_valid}, 32'd0);
    check("bp_delta_hold", delta, 32'd3);
    tick();
    exp_q.push_back(32'hFFFF_FFF8);
    pair(32'd34000, 32'd33992, 5);
    pair(32'd35000, 32'd34992, 5);
    pair(32'd36000, 32'd35992, 5);
    pair(32'd37000, 32'd36992, 5);

    // Reset in WAIT_2 after two accumulated pairs.
    pair(32'd40100, 32'd40150, 5);
    pair(32'd40200, 32'd40250, 5);
    time_1 = 32'd40000;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_delta", delta, 32'd0);
    check("mid_rst_valid", {31'd0, delta_valid}, 32'd0);
    check("mid_rst_timeout", {16'd0, timeout_count}, 32'd0);
    check("mid_rst_state", {30'd0, dut.state_q}, 32'd0);
    reset = 1'b0;
    tick();
    exp_q.push_back(32'd7);
    pair(32'd50000, 32'd50007, 5);
    pair(32'd51000, 32'd51007, 5);
    pair(32'd52000, 32'd52007, 5);
    pair(32'd53000, 32'd53007, 5);

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
